text_console_ctrl: RTL

//   Terminal-style sequencer for the 70x30 character VGA text buffer (9x16 glyph cells).

---
 rtl/text_console_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/text_console_ctrl.sv
// Terminal sequencer: ASCII keys in, one-cell text-memory write strobes out (70x30 grid).
// Latency: key accepted at edge N -> write strobe registered at edge N+1; ready again at N+2
//          (+COLS cycles for a scroll, +ROWS*COLS cycles for a form-feed).
// Backpressure: key_ready is low from acceptance until the command (and any clear) is done.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   key_valid/key_ready              key handshake; key_code (ASCII), key_color (3-bit)
//   wr_en, wr_x, wr_y, wr_char,      registered one-cell write port to text memory
//   wr_color                         (wr_y is the physical row)
//   cursor_x, cursor_y               logical cursor position
//   row_off                          physical row displayed at screen row 0
//   busy                             ~key_ready
module text_console_ctrl #(
   parameter int         COLS  = 70,
   parameter int         ROWS  = 30,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [7:0] key_code,
   input  logic [2:0] key_color,
   output logic       wr_en,
   output logic [6:0] wr_x,
   output logic [4:0] wr_y,
   output logic [7:0] wr_char,
   output logic [2:0] wr_color,
   output logic [6:0] cursor_x,
   output logic [4:0] cursor_y,
   output logic [4:0] row_off,
   output logic       busy
);

   localparam logic [6:0] X_LAST = 7'(COLS - 1);
   localparam logic [4:0] Y_LAST = 5'(ROWS - 1);
   localparam logic [5:0] ROWS6  = 6'(ROWS);

   typedef enum logic [1:0] {IDLE, EXEC, CLR_ROW, CLR_ALL} state_t;

   state_t     state, state_nx;
   logic [7:0] code_q, code_nx;
   logic [2:0] color_q, color_nx;
   logic [6:0] cx_nx;
   logic [4:0] cy_nx, ro_nx;
   logic [6:0] clr_x, clr_x_nx;
   logic [4:0] clr_y, clr_y_nx;
   logic       wr_en_nx;
   logic [6:0] wr_x_nx;
   logic [4:0] wr_y_nx;
   logic [7:0] wr_char_nx;
   logic [2:0] wr_color_nx;
   logic       ready_nx;
   logic       newline;

   // Physical row of the cursor, the row above it, and the next row offset,
   // all mod ROWS via add-then-conditional-subtract.
   logic [5:0] y_sum, ro_sum;
   logic [4:0] phys_y, phys_y_up, ro_inc;

   assign y_sum     = {1'b0, cursor_y} + {1'b0, row_off};
   assign phys_y    = (y_sum >= ROWS6) ? 5'(y_sum - ROWS6) : y_sum[4:0];
   assign phys_y_up = (phys_y == 5'd0) ? Y_LAST : phys_y - 5'd1;
   assign ro_sum    = {1'b0, row_off} + 6'd1;
   assign ro_inc    = (ro_sum >= ROWS6) ? 5'(ro_sum - ROWS6) : ro_sum[4:0];

   assign busy = ~key_ready;

   always_comb begin
      state_nx    = state;
      code_nx     = code_q;
      color_nx    = color_q;
      cx_nx       = cursor_x;
      cy_nx       = cursor_y;
      ro_nx       = row_off;
      clr_x_nx    = clr_x;
      clr_y_nx    = clr_y;
      wr_en_nx    = 1'b0;
      wr_x_nx     = wr_x;
      wr_y_nx     = wr_y;
      wr_char_nx  = wr_char;
      wr_color_nx = wr_color;
      newline     = 1'b0;

      case (state)
         IDLE: begin
            if (key_valid && key_ready) begin
               code_nx  = key_code;
               color_nx = key_color;
               state_nx = EXEC;
            end
         end

         EXEC: begin
            state_nx = IDLE;
            if (code_q >= 8'h20 && code_q <= 8'h7E) begin
               wr_en_nx    = 1'b1;
               wr_x_nx     = cursor_x;
               wr_y_nx     = phys_y;
               wr_char_nx  = code_q;
               wr_color_nx = color_q;
               if (cursor_x < X_LAST) cx_nx = cursor_x + 7'd1;
               else                   newline = 1'b1;
            end else if (code_q == 8'h0A || code_q == 8'h0D) begin
               newline = 1'b1;
            end else if (code_q == 8'h08) begin
               if (cursor_x != 7'd0) begin
                  cx_nx       = cursor_x - 7'd1;
                  wr_en_nx    = 1'b1;
                  wr_x_nx     = cursor_x - 7'd1;
                  wr_y_nx     = phys_y;
                  wr_char_nx  = BLANK;
                  wr_color_nx = 3'd0;
               end else if (cursor_y != 5'd0) begin
                  cx_nx       = X_LAST;
                  cy_nx       = cursor_y - 5'd1;
                  wr_en_nx    = 1'b1;
                  wr_x_nx     = X_LAST;
                  wr_y_nx     = phys_y_up;
                  wr_char_nx  = BLANK;
                  wr_color_nx = 3'd0;
               end
            end else if (code_q == 8'h0C) begin
               cx_nx    = 7'd0;
               cy_nx    = 5'd0;
               ro_nx    = 5'd0;
               clr_x_nx = 7'd0;
               clr_y_nx = 5'd0;
               state_nx = CLR_ALL;
            end

            // On the last row the screen scrolls: the old top physical row
            // becomes the new bottom row and must be blanked.
            if (newline) begin
               cx_nx = 7'd0;
               if (cursor_y < Y_LAST) begin
                  cy_nx = cursor_y + 5'd1;
               end else begin
                  ro_nx    = ro_inc;
                  clr_x_nx = 7'd0;
                  clr_y_nx = row_off;
                  state_nx = CLR_ROW;
               end
            end
         end

         CLR_ROW, CLR_ALL: begin
            wr_en_nx    = 1'b1;
            wr_x_nx     = clr_x;
            wr_y_nx     = clr_y;
            wr_char_nx  = BLANK;
            wr_color_nx = 3'd0;
            if (clr_x == X_LAST) begin
               clr_x_nx = 7'd0;
               if (state == CLR_ROW || clr_y == Y_LAST) state_nx = IDLE;
               else                                       clr_y_nx = clr_y + 5'd1;
            end else begin
               clr_x_nx = clr_x + 7'd1;
            end
         end

         default: state_nx = IDLE;
      endcase

      // Ready follows IDLE with one cycle of delay so it stays low while the
      // last registered write of a command is on the bus.
      ready_nx = (state == IDLE) && (state_nx == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         code_q    <= 8'd0;
         color_q   <= 3'd0;
         cursor_x  <= 7'd0;
         cursor_y  <= 5'd0;
         row_off   <= 5'd0;
         clr_x     <= 7'd0;
         clr_y     <= 5'd0;
         wr_en     <= 1'b0;
         wr_x      <= 7'd0;
         wr_y      <= 5'd0;
         wr_char   <= 8'd0;
         wr_color  <= 3'd0;
         key_ready <= 1'b1;
      end else begin
         state     <= state_nx;
         code_q    <= code_nx;
         color_q   <= color_nx;
         cursor_x  <= cx_nx;
         cursor_y  <= cy_nx;
         row_off   <= ro_nx;
         clr_x     <= clr_x_nx;
         clr_y     <= clr_y_nx;
         wr_en     <= wr_en_nx;
         wr_x      <= wr_x_nx;
         wr_y      <= wr_y_nx;
         wr_char   <= wr_char_nx;
         wr_color  <= wr_color_nx;
         key_ready <= ready_nx;
      end
   end

endmodule
